// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall mask, one-cycle flush with redirect PC,
// stall watchdog. Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module pipe_ctrl #(
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic [31:0] except_type,
  input  logic [31:0] epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout,
  output logic [31:0] stall_cnt
);

  localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);
  localparam logic [WdogW-1:0] WdogLimit = WdogW'(WDOG_LIMIT);

  // Bit i set means stage i holds; the stage just below the highest stall gets a bubble.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIf   = 6'b000011;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallAll  = 6'b111111;

  localparam logic [31:0] VecTlb     = 32'h0000_0020;
  localparam logic [31:0] VecGeneral = 32'h0000_0040;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [WdogW-1:0]  wdog_q, wdog_d, wdog_inc;
  logic              stalled;

  // Next state and stall mask
  always_comb begin
    state_d = state_q;
    stall   = StallNone;
    unique case (state_q)
      StRun: begin
        if (!rst) begin
          if (except_valid) begin
            stall   = StallAll;
            state_d = StFlush;
          end else if (stallreq_mem) begin
            stall = StallMem;
          end else if (stallreq_ex) begin
            stall = StallEx;
          end else if (stallreq_id) begin
            stall = StallId;
          end else if (stallreq_if) begin
            stall = StallIf;
          end
        end
      end
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Redirect target, captured only when leaving RUN for FLUSH
  always_comb begin
    new_pc_d = new_pc_q;
    if (state_q == StRun && state_d == StFlush) begin
      unique case (except_type)
        32'h0000_0001: new_pc_d = VecTlb;
        32'h0000_0008: new_pc_d = VecGeneral;
        32'h0000_000e: new_pc_d = epc;
        default:       new_pc_d = VecGeneral;
      endcase
    end
  end

  assign flush   = (state_q == StFlush);
  assign new_pc  = new_pc_q;
  assign stalled = (stall != StallNone);

  // Watchdog: timeout fires in the cycle whose increment would reach the limit
  assign wdog_inc = wdog_q + WdogW'(1);
  assign timeout  = stalled && (wdog_inc == WdogLimit);

  always_comb begin
    wdog_d = '0;
    if (stalled && !timeout) begin
      wdog_d = wdog_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      new_pc_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
      wdog_q   <= wdog_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stalled && stall_cnt_q != 32'hffff_ffff) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_pipe_ctrl;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        except_valid;
  logic [31:0] except_type, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;
  logic [31:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  pipe_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .except_valid(except_valid),
    .except_type (except_type),
    .epc         (epc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .timeout     (timeout),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Highest requesting stage (if=1 .. mem=4) holds itself and everything above it.
  function automatic logic [5:0] req_mask(input logic [3:0] req);
    int top = 0;
    for (int s = 0; s < 4; s++) if (req[s]) top = s + 1;
    if (top == 0) return 6'd0;
    return 6'((1 << (top + 1)) - 1);
  endfunction

  function automatic logic [31:0] target(input logic [31:0] et, input logic [31:0] pc);
    if (et == 32'h1) return 32'h20;
    if (et == 32'he) return pc;
    return 32'h40;
  endfunction

  // Model state after the most recent clock edge
  bit          m_known = 0;
  bit          m_flush = 0;
  logic [31:0] m_pc    = '0;
  int          m_run   = 0;
  longint      m_total = 0;

  initial begin
    logic [5:0]  e_stall;
    logic        e_to;
    logic [31:0] e_cnt;
    forever begin
      @(negedge clk);
      if (rst || m_flush) e_stall = 6'd0;
      else if (except_valid) e_stall = 6'h3f;
      else e_stall = req_mask({stallreq_mem, stallreq_ex, stallreq_id, stallreq_if});
      e_to = !rst && (e_stall != 6'd0) && (((m_run + 1) % int'(LIMIT)) == 0);
`ifdef STALL_CNT_EN
      e_cnt = 32'(m_total);
`else
      e_cnt = 32'd0;
`endif
      if (m_known) begin
        chk("model_stall", 32'(stall), 32'(e_stall));
        chk("model_flush", 32'(flush), 32'(m_flush));
        chk("model_new_pc", new_pc, m_pc);
        chk("model_timeout", 32'(timeout), 32'(e_to));
        chk("model_stall_cnt", stall_cnt, e_cnt);
      end
      if (rst) begin
        m_known = 1;
        m_flush = 0;
        m_pc    = '0;
        m_run   = 0;
        m_total = 0;
      end else begin
        if (!m_flush && except_valid) begin
          m_pc    = target(except_type, epc);
          m_flush = 1;
        end else begin
          m_flush = 0;
        end
        m_run = (e_stall != 6'd0) ? m_run + 1 : 0;
        if (e_stall != 6'd0 && m_total < 64'hffff_ffff) m_total++;
      end
    end
  end

  // req bits: {mem, ex, id, if}
  task automatic step(input logic r, input logic [3:0] req, input logic ev,
                      input logic [31:0] et, input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst = r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    except_valid = ev;
    except_type  = et;
    epc          = pc;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
    except_valid = 1'b0;
    except_type  = '0;
    epc          = '0;

    step(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    step(1'b1, 4'b1111, 1'b1, 32'h1, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    idle();
    chk("idle_stall", 32'(stall), 32'h0);

    // Priority encodings; the fourth consecutive stalled cycle trips the watchdog
    step(1'b0, 4'b1010, 1'b0, 32'h0, 32'h0);
    chk("id_mem_stall", 32'(stall), 32'h1f);
    step(1'b0, 4'b0010, 1'b0, 32'h0, 32'h0);
    chk("id_stall", 32'(stall), 32'h07);
    step(1'b0, 4'b0001, 1'b0, 32'h0, 32'h0);
    chk("if_stall", 32'(stall), 32'h03);
    step(1'b0, 4'b0100, 1'b0, 32'h0, 32'h0);
    chk("ex_stall", 32'(stall), 32'h0f);
    chk("mixed_timeout", 32'(timeout), 32'h1);
    idle();

    // Exception returning to epc overrides an ex stall
    step(1'b0, 4'b0100, 1'b1, 32'he, 32'h1234);
    chk("exc_stall", 32'(stall), 32'h3f);
    idle();
    chk("eret_flush", 32'(flush), 32'h1);
    chk("eret_flush_stall", 32'(stall), 32'h0);
    chk("eret_new_pc", new_pc, 32'h1234);
    idle();
    chk("eret_flush_end", 32'(flush), 32'h0);
    chk("eret_pc_hold", new_pc, 32'h1234);

    // except_valid held through FLUSH is ignored there, re-enters on return to RUN
    step(1'b0, 4'b1111, 1'b1, 32'h1, 32'h0);
    step(1'b0, 4'b1111, 1'b1, 32'h1, 32'h0);
    chk("hold_flush", 32'(flush), 32'h1);
    chk("hold_flush_stall", 32'(stall), 32'h0);
    chk("tlb_new_pc", new_pc, 32'h20);
    step(1'b0, 4'b0000, 1'b1, 32'h5, 32'h0);
    chk("hold_run_flush", 32'(flush), 32'h0);
    chk("hold_run_stall", 32'(stall), 32'h3f);
    idle();
    chk("other_new_pc", new_pc, 32'h40);
    idle();
    step(1'b0, 4'b0000, 1'b1, 32'he, 32'h5678);
    idle();
    step(1'b0, 4'b0000, 1'b1, 32'h8, 32'h0);
    idle();
    chk("syscall_new_pc", new_pc, 32'h40);
    idle();

    // Watchdog under a held ex request
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 4'b0100, 1'b0, 32'h0, 32'h0);
      chk("wdog_stall", 32'(stall), 32'h0f);
      chk("wdog_timeout", 32'(timeout), (i == 4 || i == 8) ? 32'h1 : 32'h0);
    end
    idle();

    // Reset during FLUSH aborts it
    step(1'b0, 4'b0000, 1'b1, 32'h8, 32'h0);
    step(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    chk("rst_in_flush", 32'(flush), 32'h1);
    idle();
    chk("abort_flush", 32'(flush), 32'h0);
    chk("abort_new_pc", new_pc, 32'h0);
    chk("abort_stall", 32'(stall), 32'h0);

    // Stall counter: 5 stalled, 2 idle, 3 stalled
    step(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0100, 1'b0, 32'h0, 32'h0);
    idle();
    idle();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 1'b0, 32'h0, 32'h0);
    idle();
`ifdef STALL_CNT_EN
    chk("stall_cnt_total", stall_cnt, 32'd8);
`else
    chk("stall_cnt_total", stall_cnt, 32'd0);
`endif
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
